telemetry: RTL
==============

TELEMETRY -- requirements
Module: telemetry

Interface
REQ-001 Parameter BAUD_DIV, default 2604; clocks per UART bit (19200 baud at 50 MHz); legal range 2..4095.
REQ-002 Parameter PERIOD_BITS, default 20; packet period is 2^PERIOD_BITS clocks (about 21 ms); legal range 8..24.
REQ-003 clk  input  1  system clock, 50 MHz.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 batt  input  12  battery voltage A2D result, unsigned.
REQ-006 curr  input  12  motor current A2D result, unsigned.
REQ-007 torque  input  12  pedal torque A2D result, unsigned.
REQ-008 TX  output  1  UART serial out, 8N1, LSB first, idle high; drives the top-level TX pin.
REQ-009 tx_busy  output  1  high while a packet is being shifted out.

Function
REQ-010 Free-running period counter, PERIOD_BITS wide, increments every clock and wraps; tick asserted for one clock when counter is all ones.
REQ-011 On tick with FSM IDLE: snapshot batt, curr and torque into internal registers; FSM enters START on the next edge.
REQ-012 Tick while FSM not IDLE is discarded; no queuing; next packet starts at the first tick after return to IDLE.
REQ-013 Base packet is 8 bytes, in order: 0xAA, 0x55, {4'h0,batt[11:8]}, batt[7:0], {4'h0,curr[11:8]}, curr[7:0], {4'h0,torque[11:8]}, torque[7:0].
REQ-014 FSM states: IDLE, START, DATA, STOP.
REQ-015 START drives TX=0 for BAUD_DIV clocks, then goes to DATA.
REQ-016 DATA drives bits 0..7 of the current byte, each for BAUD_DIV clocks, then goes to STOP.
REQ-017 STOP drives TX=1 for BAUD_DIV clocks; it then returns to START for the next byte, or to IDLE after the last byte.
REQ-018 There is no gap between consecutive bytes; one packet lasts NBYTES*10*BAUD_DIV clocks.
REQ-019 TX is driven from a flop (no glitches); its first low level appears on the edge after the tick cycle.
REQ-020 tx_busy is high from that same edge through the last clock of the final stop bit, and is low in IDLE.
REQ-021 Input changes during a packet do not affect the bytes sent; only the snapshot is used.
REQ-022 Baud counter is 12 bits; it clears on every bit boundary and on entering START.

Reset
REQ-023 While rst_n=0: TX=1, tx_busy=0, FSM=IDLE, and the period counter, baud counter, bit index, byte index and snapshot registers are all 0.
REQ-024 Reset asserted mid-packet aborts the packet immediately and asynchronously; after release, the first tick occurs 2^PERIOD_BITS-1 clocks later.

Configuration
REQ-025 Macro TELEMETRY_CHKSUM_EN defined: a 9th byte is appended, equal to the bitwise inverse of the mod-256 sum of bytes 3..8.
REQ-026 Macro TELEMETRY_CHKSUM_EN undefined: the packet is exactly 8 bytes and no checksum logic is synthesized.

Verification
REQ-027 Bench settings: BAUD_DIV=4, PERIOD_BITS=10, batt=0xABC, curr=0x123, torque=0x7FF.
  Required: TX falls on the edge after cycle 1023; decoded bytes are AA 55 0A BC 01 23 07 FF, plus 0F when TELEMETRY_CHKSUM_EN is defined.
  Required: tx_busy is high for 320 clocks without the checksum and 360 clocks with it.
REQ-028 Same setup, with all three inputs changed to 0x000 at the 100th clock of the packet: the decoded bytes are unchanged; the next packet carries 00 00 00 00 00 00.
REQ-029 BAUD_DIV=16, PERIOD_BITS=8 (packet of 1280 clocks exceeds the 256-clock period):
  Required: intervening ticks are ignored; each new packet starts on the first tick after tx_busy falls; there are no partial or overlapping packets.
REQ-030 rst_n pulsed low during the 3rd data bit of byte 4: TX=1 and tx_busy=0 within the same cycle, with no edge needed; a full packet then follows at cycle 1023 after release.
REQ-031 Each bit is measured at exactly BAUD_DIV clocks (±0), and the stop bit is high before every start bit.

Source files
------------

// File: rtl/telemetry.sv
// telemetry -- periodic UART telemetry packet transmitter.
//
// Every 2^PERIOD_BITS clocks the battery, current and torque A2D results are
// snapshotted and sent as one packet (8N1, LSB first, idle high):
//   AA 55 {0,batt[11:8]} batt[7:0] {0,curr[11:8]} curr[7:0]
//         {0,torque[11:8]} torque[7:0]
// Bytes are sent back to back with no gap between them.
//
// Build option:
//   TELEMETRY_CHKSUM_EN  when defined, a 9th byte is appended: the inverse of
//                        the mod-256 sum of the six payload bytes.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   batt     battery voltage A2D result (12 bit)
//   curr     motor current A2D result (12 bit)
//   torque   pedal torque A2D result (12 bit)
//   TX       UART serial output, driven from a flop
//   tx_busy  high while a packet is being shifted out
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | line idle high, waiting for the period tick
// START | start bit (TX=0) of the current byte
// DATA  | data bits 0..7 of the current byte
// STOP  | stop bit (TX=1); next byte's START or IDLE after the last byte

module telemetry #(
  parameter int BAUD_DIV    = 2604,
  parameter int PERIOD_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] batt,
  input  logic [11:0] curr,
  input  logic [11:0] torque,
  output logic        TX,
  output logic        tx_busy
);

`ifdef TELEMETRY_CHKSUM_EN
  localparam int NBYTES = 9;
`else
  localparam int NBYTES = 8;
`endif

  localparam logic [3:0]  LAST_BYTE = 4'(NBYTES - 1);
  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state_q, state_d;
  logic [PERIOD_BITS-1:0] period_q, period_d;
  logic [11:0]            baud_q, baud_d;
  logic [2:0]             bit_q, bit_d;
  logic [3:0]             byte_q, byte_d;
  logic [11:0]            batt_q, batt_d;
  logic [11:0]            curr_q, curr_d;
  logic [11:0]            torque_q, torque_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;

  logic                   tick;
  logic                   baud_done;
  logic [7:0]             cur_byte;

  assign tick      = &period_q;
  assign baud_done = (baud_q == BAUD_LAST);

`ifdef TELEMETRY_CHKSUM_EN
  logic [7:0] chksum;
  logic [7:0] sum;
  assign sum = {4'h0, batt_q[11:8]}   + batt_q[7:0]
             + {4'h0, curr_q[11:8]}   + curr_q[7:0]
             + {4'h0, torque_q[11:8]} + torque_q[7:0];
  assign chksum = ~sum;
`endif

  // Byte selected by the byte index; only the snapshot feeds the packet.
  always_comb begin
    cur_byte = 8'h00;
    case (byte_q)
      4'd0: cur_byte = 8'hAA;
      4'd1: cur_byte = 8'h55;
      4'd2: cur_byte = {4'h0, batt_q[11:8]};
      4'd3: cur_byte = batt_q[7:0];
      4'd4: cur_byte = {4'h0, curr_q[11:8]};
      4'd5: cur_byte = curr_q[7:0];
      4'd6: cur_byte = {4'h0, torque_q[11:8]};
      4'd7: cur_byte = torque_q[7:0];
`ifdef TELEMETRY_CHKSUM_EN
      4'd8: cur_byte = chksum;
`endif
      default: cur_byte = 8'h00;
    endcase
  end

  // TX is set one state ahead so the line level is always a flop output and
  // each level lasts exactly BAUD_DIV clocks.
  always_comb begin
    state_d  = state_q;
    period_d = period_q + 1'b1;
    baud_d   = baud_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    batt_d   = batt_q;
    curr_d   = curr_q;
    torque_d = torque_q;
    tx_d     = tx_q;
    busy_d   = busy_q;

    case (state_q)
      IDLE: begin
        if (tick) begin
          batt_d   = batt;
          curr_d   = curr;
          torque_d = torque;
          state_d  = START;
          baud_d   = 12'd0;
          bit_d    = 3'd0;
          byte_d   = 4'd0;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d  = 12'd0;
          bit_d   = 3'd0;
          state_d = DATA;
          tx_d    = cur_byte[0];
        end else begin
          baud_d = baud_q + 12'd1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = 12'd0;
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte[bit_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + 12'd1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = 12'd0;
          if (byte_q == LAST_BYTE) begin
            byte_d  = 4'd0;
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end else begin
            byte_d  = byte_q + 4'd1;
            state_d = START;
            tx_d    = 1'b0;
          end
        end else begin
          baud_d = baud_q + 12'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      period_q <= '0;
      baud_q   <= 12'd0;
      bit_q    <= 3'd0;
      byte_q   <= 4'd0;
      batt_q   <= 12'd0;
      curr_q   <= 12'd0;
      torque_q <= 12'd0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      batt_q   <= batt_d;
      curr_q   <= curr_d;
      torque_q <= torque_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  assign TX      = tx_q;
  assign tx_busy = busy_q;

endmodule
